// File: rtl/bp_update_queue_pkg.sv
// Shared predictor constants: default tag width and the
// branch-update handshake state encoding.
package bp_update_queue_pkg;

  localparam int BP_TAG_LEN = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_RELEASE = 2'd2
  } bp_state_e;

endpackage

// File: rtl/bp_fifo.sv
// Circular FIFO holding resolved branch outcomes awaiting
// write-back to the predictor.
module bp_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full && !rst;
  assign w_do_pop  = i_pop && !o_empty;

  // Payload storage carries no reset; pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/bp_update_queue.sv
// Buffers resolved branches from execute and writes them to
// the predictor over a WRITE/RELEASE four-phase handshake.
module bp_update_queue
  import bp_update_queue_pkg::*;
#(
  parameter int TAG_LEN = BP_TAG_LEN,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TAG_LEN-1:0]     push_tag,
  input  logic                   push_taken,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   bp_we,
  output logic [TAG_LEN-1:0]     bp_tag,
  output logic                   bp_t,
  input  logic                   bp_wack
);

  bp_state_e          r_state;
  bp_state_e          w_state_nx;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [TAG_LEN:0]   w_head;
  logic               r_bp_we;
  logic [TAG_LEN-1:0] r_bp_tag;
  logic               r_bp_t;
  logic [CNT_W-1:0]   r_drop;

  bp_fifo #(
    .W     (TAG_LEN + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_data  ({push_tag, push_taken}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count),
    .o_head  (w_head)
  );

  assign full     = w_full;
  assign drop_cnt = r_drop;
  assign bp_we    = r_bp_we;
  assign bp_tag   = r_bp_tag;
  assign bp_t     = r_bp_t;

  // Head stays queued until acked, so a reset drops it too.
  always_comb begin
    w_state_nx = r_state;
    w_pop      = 1'b0;
    unique case (1'b1)
      (r_state == ST_IDLE): begin
        if (!w_empty) w_state_nx = ST_WRITE;
      end
      (r_state == ST_WRITE): begin
        if (bp_wack) begin
          w_state_nx = ST_RELEASE;
          w_pop      = 1'b1;
        end
      end
      (r_state == ST_RELEASE): begin
        if (!bp_wack) w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bp_we  <= 1'b0;
      r_bp_tag <= '0;
      r_bp_t   <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_bp_we <= (w_state_nx == ST_WRITE);
      if (r_state == ST_IDLE && w_state_nx == ST_WRITE) begin
        r_bp_tag <= w_head[TAG_LEN:1];
        r_bp_t   <= w_head[0];
      end
      if (push && w_full && r_drop != '1)
        r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Scenario tasks plus a randomized run against a queue model
// of the branch-update buffer.
module tb_bp_update_queue;

  localparam int TAG_LEN = 10;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               push;
  logic [TAG_LEN-1:0] push_tag;
  logic               push_taken;
  logic               full;
  logic [CW-1:0]      count;
  logic [CNT_W-1:0]   drop_cnt;
  logic               bp_we;
  logic [TAG_LEN-1:0] bp_tag;
  logic               bp_t;
  logic               bp_wack;

  int n_checks = 0;
  int n_fail   = 0;

  bp_update_queue #(
    .TAG_LEN (TAG_LEN),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_tag   (push_tag),
    .push_taken (push_taken),
    .full       (full),
    .count      (count),
    .drop_cnt   (drop_cnt),
    .bp_we      (bp_we),
    .bp_tag     (bp_tag),
    .bp_t       (bp_t),
    .bp_wack    (bp_wack)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; push = 1'b0; bp_wack = 1'b0;
    push_tag = '0; push_taken = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; push = 1'b1; push_tag = 10'h3ff;
    push_taken = 1'b1; bp_wack = 1'b1;
    tick;
    n_checks++;
    if (bp_we !== 1'b0 || count !== '0 || full !== 1'b0 ||
        drop_cnt !== '0 || bp_tag !== '0 || bp_t !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: we=%b cnt=%0d full=%b drop=%0d tag=%h t=%b want all 0",
               bp_we, count, full, drop_cnt, bp_tag, bp_t);
    end
    rst = 1'b0; push = 1'b0; bp_wack = 1'b0;
    tick;
    n_checks++;
    if (count !== '0) begin
      n_fail++;
      $display("FAIL reset_push_ignored: count=%0d want 0", count);
    end
  endtask

  task automatic test_single;
    do_reset;
    push = 1'b1; push_tag = 10'h155; push_taken = 1'b1;
    tick;
    push = 1'b0;
    n_checks++;
    if (bp_we !== 1'b0 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL single_c1: we=%b cnt=%0d want 0/1", bp_we, count);
    end
    tick;
    n_checks++;
    if (bp_we !== 1'b1 || bp_tag !== 10'h155 || bp_t !== 1'b1) begin
      n_fail++;
      $display("FAIL single_c2: we=%b tag=%h t=%b want 1/155/1", bp_we, bp_tag, bp_t);
    end
    bp_wack = 1'b1;
    tick;
    bp_wack = 1'b0;
    n_checks++;
    if (bp_we !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL single_ack: we=%b cnt=%0d want 0/0", bp_we, count);
    end
    tick;
  endtask

  task automatic test_full_drop;
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      push = 1'b1; push_tag = 10'(16 + i); push_taken = i[0];
      tick;
    end
    push = 1'b0;
    n_checks++;
    if (full !== 1'b1 || count !== CW'(DEPTH)) begin
      n_fail++;
      $display("FAIL full_set: full=%b cnt=%0d want 1/%0d", full, count, DEPTH);
    end
    push = 1'b1; tick; tick; push = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'd2 || count !== CW'(DEPTH) || bp_tag !== 10'h010) begin
      n_fail++;
      $display("FAIL full_drop: drop=%0d cnt=%0d tag=%h want 2/%0d/010",
               drop_cnt, count, bp_tag, DEPTH);
    end
  endtask

  task automatic test_order;
    logic [TAG_LEN-1:0] exp_tags[3];
    int n = 0;
    logic prev_we = 1'b0;
    logic b2b = 1'b0;
    exp_tags[0] = 10'h001; exp_tags[1] = 10'h002; exp_tags[2] = 10'h003;
    do_reset;
    for (int i = 0; i < 40; i++) begin
      if (bp_we) begin
        if (prev_we) b2b = 1'b1;
        n_checks++;
        if (n >= 3 || bp_tag !== exp_tags[n < 3 ? n : 0]) begin
          n_fail++;
          $display("FAIL order_tag[%0d]: got %h want %h", n, bp_tag, exp_tags[n < 3 ? n : 0]);
        end
        n++;
      end
      prev_we = bp_we;
      bp_wack = bp_we;
      push = (i < 3); push_tag = 10'(i + 1); push_taken = 1'b0;
      tick;
    end
    push = 1'b0; bp_wack = 1'b0;
    n_checks++;
    if (n != 3 || b2b) begin
      n_fail++;
      $display("FAIL order_count: delivered=%0d b2b=%b want 3/0", n, b2b);
    end
  endtask

  task automatic test_wack_hold;
    int seen_we = 0;
    do_reset;
    push = 1'b1; push_tag = 10'h021; push_taken = 1'b1; tick;
    push_tag = 10'h022; push_taken = 1'b0; tick;
    push = 1'b0;
    for (int k = 0; k < 10 && !bp_we; k++) tick;
    n_checks++;
    if (bp_we !== 1'b1 || bp_tag !== 10'h021) begin
      n_fail++;
      $display("FAIL hold_first: we=%b tag=%h want 1/021", bp_we, bp_tag);
    end
    bp_wack = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (bp_we) seen_we++;
    end
    n_checks++;
    if (seen_we != 0 || count !== CW'(1)) begin
      n_fail++;
      $display("FAIL hold_release: strobes=%0d cnt=%0d want 0/1", seen_we, count);
    end
    bp_wack = 1'b0;
    tick;
    n_checks++;
    if (bp_we !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: we=%b want 0", bp_we);
    end
    tick;
    n_checks++;
    if (bp_we !== 1'b1 || bp_tag !== 10'h022 || bp_t !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_second: we=%b tag=%h t=%b want 1/022/0", bp_we, bp_tag, bp_t);
    end
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_tag = 10'(48 + i); push_taken = 1'b1;
      tick;
    end
    push = 1'b0;
    n_checks++;
    if (bp_we !== 1'b1 || count !== CW'(3)) begin
      n_fail++;
      $display("FAIL rstmid_pre: we=%b cnt=%0d want 1/3", bp_we, count);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (bp_we !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL rstmid_post: we=%b cnt=%0d want 0/0", bp_we, count);
    end
    for (int i = 0; i < 12; i++) begin
      if (bp_we) stale++;
      bp_wack = bp_we;
      tick;
    end
    bp_wack = 1'b0;
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL rstmid_stale: strobes=%0d want 0", stale);
    end
  endtask

  task automatic test_push_ack;
    do_reset;
    for (int i = 0; i < DEPTH - 1; i++) begin
      push = 1'b1; push_tag = 10'(64 + i); push_taken = 1'b0;
      tick;
    end
    push = 1'b1; push_tag = 10'h044; bp_wack = 1'b1;
    n_checks++;
    if (bp_we !== 1'b1) begin
      n_fail++;
      $display("FAIL pushack_we: we=%b want 1", bp_we);
    end
    tick;
    push = 1'b0; bp_wack = 1'b0;
    n_checks++;
    if (count !== CW'(DEPTH - 1) || drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL pushack: cnt=%0d drop=%0d want %0d/0", count, drop_cnt, DEPTH - 1);
    end
  endtask

  task automatic test_drop_sat;
    do_reset;
    push = 1'b1; push_tag = 10'h077;
    for (int i = 0; i < DEPTH + 260; i++) tick;
    push = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL drop_sat: drop=%0d want 255", drop_cnt);
    end
  endtask

  task automatic test_random;
    logic [TAG_LEN:0] q[$];
    int drops = 0;
    int bad = 0;
    do_reset;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc < 500) begin
        push       = ($urandom_range(0, 1) == 1);
        push_tag   = 10'($urandom);
        push_taken = 1'($urandom);
        bp_wack    = ($urandom_range(0, 1) == 1);
      end else begin
        push    = 1'b0;
        bp_wack = bp_we;
      end
      if (bp_we) begin
        n_checks++;
        if (q.size() == 0 || {bp_tag, bp_t} !== q[0]) begin
          n_fail++;
          $display("FAIL rand_deliver cyc%0d: got %h/%b want %h (qsize %0d)",
                   cyc, bp_tag, bp_t, q.size() ? q[0] : '0, q.size());
        end
      end
      if (push && q.size() >= DEPTH && drops < 255) drops++;
      if (bp_we && bp_wack && q.size() > 0) void'(q.pop_front());
      if (push && q.size() + ((bp_we && bp_wack) ? 1 : 0) < DEPTH)
        q.push_back({push_tag, push_taken});
      tick;
      if (count !== CW'(q.size()) || full !== (q.size() == DEPTH) ||
          drop_cnt !== CNT_W'(drops)) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand_state cyc%0d: cnt=%0d full=%b drop=%0d want %0d/%b/%0d",
                   cyc, count, full, drop_cnt, q.size(), q.size() == DEPTH, drops);
      end
    end
    bp_wack = 1'b0;
    n_checks++;
    if (bad != 0) n_fail++;
    n_checks++;
    if (q.size() != 0 || count !== '0) begin
      n_fail++;
      $display("FAIL rand_drain: model=%0d cnt=%0d want 0/0", q.size(), count);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_full_drop;
    test_order;
    test_wack_hold;
    test_reset_mid;
    test_push_ack;
    test_drop_sat;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
